// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode FSM, 1 Hz / 2 Hz dividers and MM:SS time registers.
// Optional macro ADJ_BLINK_EN enables the adjust-field blink mask.
module stopwatch_ctrl #(
   parameter int DIV_1HZ = 100000000,
   parameter int DIV_2HZ = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       clr,
   input  logic       adj,
   input  logic       sel,
   output logic [2:0] m10,
   output logic [3:0] m1,
   output logic [2:0] s10,
   output logic [3:0] s1,
   output logic [1:0] mode,
   output logic       led,
   output logic       tick_2hz,
   output logic [1:0] blink_mask
);

   localparam int W1 = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
   localparam int W2 = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
   localparam logic [W1-1:0] D1_MAX = W1'(DIV_1HZ - 1);
   localparam logic [W2-1:0] D2_MAX = W2'(DIV_2HZ - 1);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'b00,
      ST_RUN    = 2'b01,
      ST_ADJ    = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic          resume_q, resume_d;
   logic [W1-1:0] div1_q, div1_d;
   logic [W2-1:0] div2_q, div2_d;
   logic [2:0]    m10_q, m10_d;
   logic [3:0]    m1_q, m1_d;
   logic [2:0]    s10_q, s10_d;
   logic [3:0]    s1_q, s1_d;
   logic          led_q, led_d;
   logic          tick2_q, tick2_d;
   logic [1:0]    bmask_q, bmask_d;

   logic tick_1hz;
   logic tick2_int;
   logic adj_entry;

   assign tick_1hz  = (div1_q == D1_MAX);
   assign tick2_int = (div2_q == D2_MAX);
   assign adj_entry = (state_d == ST_ADJ) && (state_q != ST_ADJ);

   // Mode sequencing; adj takes precedence over a same-cycle pause.
   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      unique case (state_q)
         ST_PAUSED: begin
            if (adj) begin
               state_d  = ST_ADJ;
               resume_d = 1'b0;
            end else if (pause) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (adj) begin
               state_d  = ST_ADJ;
               resume_d = 1'b1;
            end else if (pause) begin
               state_d = ST_PAUSED;
            end
         end
         ST_ADJ: begin
            if (!adj) state_d = resume_q ? ST_RUN : ST_PAUSED;
         end
         default: state_d = ST_PAUSED;
      endcase
   end

   // Dividers: div1 free-runs, div2 restarts when adjust begins.
   always_comb begin
      div1_d = tick_1hz ? '0 : div1_q + W1'(1);
      div2_d = tick2_int ? '0 : div2_q + W2'(1);
      if (adj_entry) div2_d = '0;
   end

   // Time update: clear, carry chain in RUN, single-field bump in ADJUST.
   always_comb begin
      m10_d = m10_q;
      m1_d  = m1_q;
      s10_d = s10_q;
      s1_d  = s1_q;
      if (clr) begin
         m10_d = '0;
         m1_d  = '0;
         s10_d = '0;
         s1_d  = '0;
      end else if (state_q == ST_RUN && tick_1hz) begin
         if (s1_q != 4'd9) begin
            s1_d = s1_q + 4'd1;
         end else begin
            s1_d = '0;
            if (s10_q != 3'd5) begin
               s10_d = s10_q + 3'd1;
            end else begin
               s10_d = '0;
               if (m1_q != 4'd9) begin
                  m1_d = m1_q + 4'd1;
               end else begin
                  m1_d  = '0;
                  m10_d = (m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1;
               end
            end
         end
      end else if (state_q == ST_ADJ && tick2_int) begin
         if (sel) begin
            if (s1_q != 4'd9) begin
               s1_d = s1_q + 4'd1;
            end else begin
               s1_d  = '0;
               s10_d = (s10_q == 3'd5) ? 3'd0 : s10_q + 3'd1;
            end
         end else begin
            if (m1_q != 4'd9) begin
               m1_d = m1_q + 4'd1;
            end else begin
               m1_d  = '0;
               m10_d = (m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1;
            end
         end
      end
   end

   // Registered status outputs track the upcoming mode.
   always_comb begin
      led_d   = (state_d == ST_ADJ);
      tick2_d = tick2_int;
   end

`ifdef ADJ_BLINK_EN
   logic phase_q, phase_d;

   // Blink phase flips per 2 Hz tick in adjust; mask blanks the chosen field.
   always_comb begin
      phase_d = phase_q;
      if (adj_entry) begin
         phase_d = 1'b0;
      end else if (state_q == ST_ADJ && tick2_int) begin
         phase_d = ~phase_q;
      end
      bmask_d = 2'b00;
      if (state_d == ST_ADJ && phase_d) bmask_d = sel ? 2'b01 : 2'b10;
   end

   // Blink phase register.
   always_ff @(posedge clk) begin
      if (rst) phase_q <= 1'b0;
      else     phase_q <= phase_d;
   end
`else
   // No blinking: mask is permanently clear.
   always_comb begin
      bmask_d = 2'b00;
   end
`endif

   // State, divider, time and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_PAUSED;
         resume_q <= 1'b0;
         div1_q   <= '0;
         div2_q   <= '0;
         m10_q    <= '0;
         m1_q     <= '0;
         s10_q    <= '0;
         s1_q     <= '0;
         led_q    <= 1'b0;
         tick2_q  <= 1'b0;
         bmask_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         div1_q   <= div1_d;
         div2_q   <= div2_d;
         m10_q    <= m10_d;
         m1_q     <= m1_d;
         s10_q    <= s10_d;
         s1_q     <= s1_d;
         led_q    <= led_d;
         tick2_q  <= tick2_d;
         bmask_q  <= bmask_d;
      end
   end

   assign m10        = m10_q;
   assign m1         = m1_q;
   assign s10        = s10_q;
   assign s1         = s1_q;
   assign mode       = state_q;
   assign led        = led_q;
   assign tick_2hz   = tick2_q;
   assign blink_mask = bmask_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode controller and time-register owner for the lab stopwatch.
- Generates the 1 Hz count tick and the 2 Hz adjust tick from the system clock.
- Sequences RUN / PAUSED / ADJUST modes and applies either normal MM:SS carry counting or per-field adjust increments.
- Sits between the debounced button/switch inputs and the 7-segment display driver.

Parameters:
- DIV_1HZ, 100000000, clk cycles per tick_1hz period (>=2)
- DIV_2HZ, 50000000, clk cycles per tick_2hz period (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pause  in  1  debounced single-cycle pulse; toggles RUN/PAUSED
- clr  in  1  debounced single-cycle pulse; clears time to 00:00
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; adjust field select, 1 = seconds, 0 = minutes
- m10  out  3  minutes tens, 0..5
- m1  out  4  minutes ones, 0..9
- s10  out  3  seconds tens, 0..5
- s1  out  4  seconds ones, 0..9
- mode  out  2  00 PAUSED, 01 RUN, 10 ADJUST
- led  out  1  1 while mode==ADJUST
- tick_2hz  out  1  one-cycle 2 Hz strobe, for the display blink/refresh
- blink_mask  out  2  bit1 = blank minutes digits, bit0 = blank seconds digits

Behaviour:
- All registers update on posedge clk. rst has priority over every other input.
- Reset values:
  - time = 00:00
  - mode = PAUSED; resume bit = 0
  - led = 0; tick_2hz = 0; blink_mask = 00
  - both divider counters = 0; blink phase = 0
- Dividers:
  - div1 counts 0..DIV_1HZ-1 and wraps. tick_1hz (internal) = 1 in the cycle div1 == DIV_1HZ-1.
  - div2 works the same way with DIV_2HZ.
  - div1 free-runs and is never cleared by clr or by a mode change.
  - div2 is zeroed in the cycle ADJUST is entered.
- State machine:
  - PAUSED: pause=1 -> RUN. adj=1 -> ADJUST with resume=0.
  - RUN: pause=1 -> PAUSED. adj=1 -> ADJUST with resume=1.
  - ADJUST: adj=0 -> RUN if resume=1, else PAUSED. pause is ignored.
  - adj=1 overrides a same-cycle pause in every state.
- RUN counting, applied on tick_1hz and registered 1 cycle after the tick:
  - s1 wraps 9->0 and carries into s10.
  - s10 wraps 5->0 and carries into m1.
  - m1 wraps 9->0 and carries into m10.
  - m10 wraps 5->0, so 59:59 -> 00:00.
- PAUSED: time holds.
- ADJUST counting, applied on tick_2hz:
  - Only the selected field increments, as a 2-digit 00..59 counter; 59 -> 00.
  - No carry out of the selected field. The other field holds.
  - sel is sampled in the tick cycle.
  - tick_1hz has no effect on time in ADJUST.
- clr:
  - Sets time = 00:00 next cycle in any mode; mode is unchanged.
  - clr beats a same-cycle tick: the result is 00:00, not 00:01.
- Outputs are registered. An out-of-range time is unreachable; there is no recovery logic for it.
- rst asserted mid-count or mid-adjust behaves exactly as the reset state on the next edge.

Optional Feature:
- Macro: ADJ_BLINK_EN.
- Defined:
  - A blink phase bit toggles on each tick_2hz while in ADJUST and is cleared on ADJUST entry.
  - blink_mask = phase ? (sel ? 01 : 10) : 00 while in ADJUST; 00 otherwise.
  - The result is a 1 Hz blink of the selected field.
- Undefined: blink_mask is tied to 00 and no phase register exists.
- All other behaviour is identical with or without the macro.

Test Plan (DIV_1HZ=4, DIV_2HZ=2):
- Reset then pause pulse -> mode=01. After 4*60 cycles -> time 01:00; s1 ticks every 4 cycles.
- Preload 59:59 via adjust, then RUN one tick -> 00:00. The 09:59 -> 10:00 carry is also checked.
- PAUSED at 00:07, adj=1, sel=1, 30 cycles -> seconds 07->22 (15 ticks) while minutes hold. At seconds=59, the next tick gives 00 with minutes unchanged.
- RUN, adj=1, sel=0, 4 cycles, adj=0 -> minutes +2, mode returns to 01. The same sequence from PAUSED returns to 00.
- clr coincident with tick_1hz at 03:41 -> 00:00 next cycle, mode unchanged. pause coincident with adj rise -> mode=10, and resume reflects the pre-adj state.
- With ADJ_BLINK_EN: in ADJUST with sel=0, blink_mask alternates 10/00 each tick_2hz. On exiting ADJUST -> 00. Without the macro, blink_mask stays 00 throughout.
